// File: rtl/fdiv_unit_if.sv
// Start/done port bundle between the core's FP issue logic and the FDIV.S unit.
// Handshake: the core raises iStart with operands and iRd for one cycle while
// oBusy is low; the unit latches them only when idle, raises oBusy for the whole
// computation and reports with a single-cycle oDone (== oRegWrite) carrying
// oWriteRegister/oResult/oFlags. There is no backpressure and no queueing.
interface fdiv_unit_if;
  logic        iStart;
  logic [31:0] iOperandA;
  logic [31:0] iOperandB;
  logic [4:0]  iRd;
  logic        oBusy;
  logic        oDone;
  logic        oRegWrite;
  logic [4:0]  oWriteRegister;
  logic [31:0] oResult;
  logic [4:0]  oFlags;
  logic [2:0]  dbgState;

  modport master (
    output iStart, iOperandA, iOperandB, iRd,
    input  oBusy, oDone, oRegWrite, oWriteRegister, oResult, oFlags, dbgState
  );

  modport slave (
    input  iStart, iOperandA, iOperandB, iRd,
    output oBusy, oDone, oRegWrite, oWriteRegister, oResult, oFlags, dbgState
  );
endinterface

// File: rtl/fdiv_unit.sv
// Multi-cycle IEEE-754 single-precision divider feeding the FP register file
// write port: restoring mantissa division, RNE rounding, DAZ and flush-to-zero.
module fdiv_unit #(
  parameter int          ITER      = 26,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input logic        iCLK,
  input logic        iRST_N,
  fdiv_unit_if.slave divBus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PREP  = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int                CNT_W    = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       opA, opB;
  logic [4:0]        rdReg;
  logic              sign;
  logic signed [9:0] expReg;
  logic [23:0]       divisor;
  logic [24:0]       rem;
  logic [25:0]       quo;
  logic              specValid;
  logic [31:0]       specRes;
  logic [4:0]        specFlags;
  logic [31:0]       resReg;
  logic [4:0]        flagsReg;
  logic              doneOut;
  logic [31:0]       resultOut;
  logic [4:0]        flagsOut;
  logic [4:0]        wrOut;

  // Operand unpack; exponent-zero encodings (zero and subnormal) count as zero.
  logic [7:0]        eA, eB;
  logic [22:0]       fA, fB;
  logic              aZero, bZero, aInf, bInf, aNan, bNan, aSnan, bSnan, qSign;
  logic signed [9:0] expPrep;

  assign eA      = opA[30:23];
  assign eB      = opB[30:23];
  assign fA      = opA[22:0];
  assign fB      = opB[22:0];
  assign aZero   = (eA == 8'h00);
  assign bZero   = (eB == 8'h00);
  assign aInf    = (eA == 8'hFF) && (fA == 23'd0);
  assign bInf    = (eB == 8'hFF) && (fB == 23'd0);
  assign aNan    = (eA == 8'hFF) && (fA != 23'd0);
  assign bNan    = (eB == 8'hFF) && (fB != 23'd0);
  assign aSnan   = aNan && !fA[22];
  assign bSnan   = bNan && !fB[22];
  assign qSign   = opA[31] ^ opB[31];
  assign expPrep = $signed({2'b00, eA}) - $signed({2'b00, eB}) + 10'sd127;

  logic        specHit;
  logic [31:0] specVal;
  logic [4:0]  specFl;

  always_comb begin
    specHit = 1'b1;
    specVal = CANON_NAN;
    specFl  = 5'b00000;
    if (aNan || bNan) begin
      specFl = {aSnan || bSnan, 4'b0000};
    end else if ((aZero && bZero) || (aInf && bInf)) begin
      specFl = 5'b10000;
    end else if (aInf) begin
      specVal = {qSign, 8'hFF, 23'd0};
    end else if (bZero) begin
      specVal = {qSign, 8'hFF, 23'd0};
      specFl  = 5'b01000;
    end else if (bInf || aZero) begin
      specVal = {qSign, 31'd0};
    end else begin
      specHit = 1'b0;
    end
  end

  // One restoring step; the partial remainder always stays below the divisor.
  logic        remGe;
  logic [23:0] remSub;

  assign remGe  = (rem >= {1'b0, divisor});
  assign remSub = remGe ? 24'(rem - {1'b0, divisor}) : rem[23:0];

  // Quotient layout: bit 25 integer bit, 23 fraction, guard, round.
  logic [24:0]       norm;
  logic signed [9:0] expNorm, expFinal;
  logic [22:0]       fracRnd;
  logic              guardBit, roundBit, stickyBit, roundUp, carry, inexact;
  logic [31:0]       roundRes;
  logic [4:0]        roundFl;

  always_comb begin
    norm      = quo[25] ? quo[24:0] : {quo[23:0], 1'b0};
    expNorm   = quo[25] ? expReg : expReg - 10'sd1;
    guardBit  = norm[1];
    roundBit  = norm[0];
    stickyBit = |rem;
    roundUp   = guardBit & (roundBit | stickyBit | norm[2]);
    fracRnd   = norm[24:2] + {22'd0, roundUp};
    carry     = (&norm[24:2]) & roundUp;
    expFinal  = expNorm + $signed({9'd0, carry});
    inexact   = guardBit | roundBit | stickyBit;
    roundRes  = {sign, expFinal[7:0], fracRnd};
    roundFl   = {4'b0000, inexact};
    if (specValid) begin
      roundRes = specRes;
      roundFl  = specFlags;
    end else if (expFinal >= 10'sd255) begin
      roundRes = {sign, 8'hFF, 23'd0};
      roundFl  = 5'b00101;
    end else if (expFinal <= 10'sd0) begin
      roundRes = {sign, 31'd0};
      roundFl  = 5'b00011;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      opA       <= '0;
      opB       <= '0;
      rdReg     <= '0;
      sign      <= 1'b0;
      expReg    <= '0;
      divisor   <= '0;
      rem       <= '0;
      quo       <= '0;
      specValid <= 1'b0;
      specRes   <= '0;
      specFlags <= '0;
      resReg    <= '0;
      flagsReg  <= '0;
      doneOut   <= 1'b0;
      resultOut <= '0;
      flagsOut  <= '0;
      wrOut     <= '0;
    end else begin
      doneOut <= 1'b0;
      case (state)
        IDLE: begin
          if (divBus.iStart) begin
            opA   <= divBus.iOperandA;
            opB   <= divBus.iOperandB;
            rdReg <= divBus.iRd;
            state <= PREP;
          end
        end
        PREP: begin
          sign      <= qSign;
          expReg    <= expPrep;
          divisor   <= {1'b1, fB};
          rem       <= {2'b01, fA};
          quo       <= '0;
          cnt       <= '0;
          specValid <= specHit;
          specRes   <= specVal;
          specFlags <= specFl;
          state     <= DIV;
        end
        DIV: begin
          rem <= {remSub, 1'b0};
          quo <= {quo[24:0], remGe};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) state <= ROUND;
        end
        ROUND: begin
          resReg   <= roundRes;
          flagsReg <= roundFl;
          state    <= DONE;
        end
        DONE: begin
          // The writeback triple is published on the exit edge of DONE.
          doneOut   <= 1'b1;
          resultOut <= resReg;
          flagsOut  <= flagsReg;
          wrOut     <= rdReg;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign divBus.oBusy          = (state == PREP) || (state == DIV) || (state == ROUND);
  assign divBus.oDone          = doneOut;
  assign divBus.oRegWrite      = doneOut;
  assign divBus.oWriteRegister = wrOut;
  assign divBus.oResult        = resultOut;
  assign divBus.oFlags         = flagsOut;
  assign divBus.dbgState       = state;

endmodule

// File: tb/tb_fdiv_unit.sv
// Self-checking bench for fdiv_unit: scoreboard of expected writebacks checked
// on every oDone, plus latency, handshake and reset scenarios.
module tb_fdiv_unit;

  logic iCLK   = 1'b0;
  logic iRST_N = 1'b0;

  always #5 iCLK = ~iCLK;

  fdiv_unit_if bus ();

  fdiv_unit #(
    .ITER      (26),
    .CANON_NAN (32'h7FC00000)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .divBus (bus)
  );

  // Scoreboard entries are {rd[4:0], flags[4:0], result[31:0]}.
  logic [41:0] exp_q[$];
  logic [41:0] sb_item;
  int          checks = 0;
  int          passes = 0;
  string       cur_test = "init";

  always @(negedge iCLK) begin
    if (bus.oDone === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s unexpected_done: got oDone=1 rd=%0d result=%h, required no writeback",
                 cur_test, bus.oWriteRegister, bus.oResult);
      end else begin
        passes++;
        sb_item = exp_q.pop_front();
        checks++;
        if (bus.oResult !== sb_item[31:0])
          $display("FAIL %s result: got %h expected %h", cur_test, bus.oResult, sb_item[31:0]);
        else passes++;
        checks++;
        if (bus.oFlags !== sb_item[36:32])
          $display("FAIL %s flags: got %b expected %b", cur_test, bus.oFlags, sb_item[36:32]);
        else passes++;
        checks++;
        if (bus.oWriteRegister !== sb_item[41:37])
          $display("FAIL %s rd: got %0d expected %0d", cur_test, bus.oWriteRegister, sb_item[41:37]);
        else passes++;
        checks++;
        if (bus.oRegWrite !== 1'b1)
          $display("FAIL %s regwrite: got %b expected 1", cur_test, bus.oRegWrite);
        else passes++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.iOperandA = a;
    bus.iOperandB = b;
    bus.iRd       = rd;
    bus.iStart    = 1'b1;
    @(posedge iCLK);
    #1;
    bus.iStart = 1'b0;
  endtask

  // Returns cycles from the start sample edge to oDone (0 on timeout) and the
  // number of computing cycles in which oBusy was low. Optionally pulses a
  // second start with other operands at cycle inject_at.
  task automatic wait_done(output int lat, output int busy_low, input int inject_at);
    lat      = 0;
    busy_low = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge iCLK);
      #1;
      if (n == inject_at) begin
        bus.iOperandA = 32'h3F800000;
        bus.iOperandB = 32'h40400000;
        bus.iRd       = 5'd9;
        bus.iStart    = 1'b1;
      end
      if (n == inject_at + 1) bus.iStart = 1'b0;
      if (bus.oDone === 1'b1) begin
        lat = n;
        break;
      end
      if (n <= 27 && bus.oBusy !== 1'b1) busy_low++;
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] er, input logic [4:0] ef, output int lat);
    int bl;
    start_op(a, b, rd);
    exp_q.push_back({rd, ef, er});
    wait_done(lat, bl, 0);
    @(posedge iCLK);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    cur_test      = "reset";
    iRST_N        = 1'b0;
    bus.iStart    = 1'b0;
    bus.iOperandA = '0;
    bus.iOperandB = '0;
    bus.iRd       = '0;
    repeat (3) @(posedge iCLK);
    #1;
    checks++;
    if ({bus.oBusy, bus.oDone, bus.oRegWrite} !== 3'b000)
      $display("FAIL reset ctrl: got busy/done/we=%b expected 000", {bus.oBusy, bus.oDone, bus.oRegWrite});
    else passes++;
    checks++;
    if (bus.oResult !== 32'h0) $display("FAIL reset result: got %h expected 00000000", bus.oResult);
    else passes++;
    checks++;
    if ({bus.oWriteRegister, bus.oFlags} !== 10'h0)
      $display("FAIL reset rd_flags: got %0d/%b expected 0/00000", bus.oWriteRegister, bus.oFlags);
    else passes++;
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(posedge iCLK);
    #1;
    checks++;
    if (bus.dbgState !== 3'd0 || bus.oBusy !== 1'b0)
      $display("FAIL reset idle: got state=%0d busy=%b expected 0/0", bus.dbgState, bus.oBusy);
    else passes++;
  endtask

  task automatic test_basic;
    int lat, bl;
    cur_test = "basic";
    start_op(32'h40C00000, 32'h40000000, 5'd5);
    exp_q.push_back({5'd5, 5'b00000, 32'h40400000});
    wait_done(lat, bl, 0);
    checks++;
    if (lat !== 29) $display("FAIL basic latency: got %0d expected 29", lat);
    else passes++;
    checks++;
    if (bl !== 0) $display("FAIL basic busy: got %0d low cycles expected 0", bl);
    else passes++;
    @(posedge iCLK);
    #1;
    checks++;
    if (bus.oDone !== 1'b0 || bus.oRegWrite !== 1'b0)
      $display("FAIL basic pulse: got done/we=%b%b one cycle later expected 00", bus.oDone, bus.oRegWrite);
    else passes++;
  endtask

  task automatic test_vectors;
    logic [31:0] va[9], vb[9], vr[9];
    logic [4:0]  vf[9];
    int lat;
    cur_test = "vectors";
    va[0] = 32'h3F800000; vb[0] = 32'h40400000; vr[0] = 32'h3EAAAAAB; vf[0] = 5'b00001;
    va[1] = 32'hC0000000; vb[1] = 32'h3F800000; vr[1] = 32'hC0000000; vf[1] = 5'b00000;
    va[2] = 32'h3F800000; vb[2] = 32'h00000000; vr[2] = 32'h7F800000; vf[2] = 5'b01000;
    va[3] = 32'h00000000; vb[3] = 32'h80000000; vr[3] = 32'h7FC00000; vf[3] = 5'b10000;
    va[4] = 32'h7F800001; vb[4] = 32'h3F800000; vr[4] = 32'h7FC00000; vf[4] = 5'b10000;
    va[5] = 32'h7FC00000; vb[5] = 32'h3F800000; vr[5] = 32'h7FC00000; vf[5] = 5'b00000;
    va[6] = 32'h7F7FFFFF; vb[6] = 32'h3E800000; vr[6] = 32'h7F800000; vf[6] = 5'b00101;
    va[7] = 32'h00800000; vb[7] = 32'h7F000000; vr[7] = 32'h00000000; vf[7] = 5'b00011;
    va[8] = 32'h00000001; vb[8] = 32'h3F800000; vr[8] = 32'h00000000; vf[8] = 5'b00000;
    for (int i = 0; i < 9; i++) begin
      run_div(va[i], vb[i], 5'(i + 10), vr[i], vf[i], lat);
      checks++;
      if (lat !== 29) $display("FAIL vectors latency[%0d]: got %0d expected 29", i, lat);
      else passes++;
    end
  endtask

  // Dividing by a power of two only moves the exponent: exact, flags clear.
  task automatic test_random_pow2;
    logic [31:0] a, b, r;
    logic [7:0]  ea;
    logic [22:0] fr;
    logic        sa, sb;
    int          j, lat;
    cur_test = "random_pow2";
    for (int i = 0; i < 4; i++) begin
      ea = 8'($urandom_range(100, 200));
      fr = 23'($urandom_range(0, 32'h7FFFFF));
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      j  = $urandom_range(0, 20);
      a  = {sa, ea, fr};
      b  = {sb, 8'(127 + j), 23'd0};
      r  = {sa ^ sb, 8'(ea - 8'(j)), fr};
      run_div(a, b, 5'($urandom_range(0, 31)), r, 5'b00000, lat);
      checks++;
      if (lat !== 29) $display("FAIL random_pow2 latency[%0d]: got %0d expected 29", i, lat);
      else passes++;
    end
  endtask

  task automatic test_back_to_back;
    int lat, bl;
    cur_test = "back_to_back";
    start_op(32'h40C00000, 32'h40000000, 5'd7);
    exp_q.push_back({5'd7, 5'b00000, 32'h40400000});
    wait_done(lat, bl, 5);
    checks++;
    if (lat !== 29) $display("FAIL back_to_back latency1: got %0d expected 29", lat);
    else passes++;
    checks++;
    if (bl !== 0) $display("FAIL back_to_back busy: got %0d low cycles expected 0", bl);
    else passes++;
    @(posedge iCLK);
    #1;
    start_op(32'h3F800000, 32'h40400000, 5'd11);
    exp_q.push_back({5'd11, 5'b00001, 32'h3EAAAAAB});
    wait_done(lat, bl, 0);
    checks++;
    if (lat !== 29) $display("FAIL back_to_back latency2: got %0d expected 29", lat);
    else passes++;
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    cur_test = "reset_mid";
    start_op(32'h40C00000, 32'h40000000, 5'd3);
    repeat (11) @(posedge iCLK);
    #1;
    checks++;
    if (bus.dbgState !== 3'd2) $display("FAIL reset_mid in_div: got state=%0d expected 2", bus.dbgState);
    else passes++;
    #2;
    iRST_N = 1'b0;
    #1;
    checks++;
    if ({bus.oBusy, bus.oDone, bus.oRegWrite} !== 3'b000 || bus.dbgState !== 3'd0)
      $display("FAIL reset_mid ctrl: got busy/done/we=%b state=%0d expected 000/0",
               {bus.oBusy, bus.oDone, bus.oRegWrite}, bus.dbgState);
    else passes++;
    checks++;
    if ({bus.oResult, bus.oFlags, bus.oWriteRegister} !== 42'h0)
      $display("FAIL reset_mid data: got %h/%b/%0d expected 0", bus.oResult, bus.oFlags, bus.oWriteRegister);
    else passes++;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    @(posedge iCLK);
    #1;
    run_div(32'h40C00000, 32'h40000000, 5'd4, 32'h40400000, 5'b00000, lat);
    checks++;
    if (lat !== 29) $display("FAIL reset_mid latency: got %0d expected 29", lat);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_random_pow2();
    test_back_to_back();
    test_reset_mid();
    repeat (40) @(posedge iCLK);
    #1;
    cur_test = "final";
    checks++;
    if (exp_q.size() !== 0) $display("FAIL final drain: got %0d pending results expected 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fdiv_unit.md
Name: fdiv_unit

Overview:
Multi-cycle IEEE-754 single-precision divider (FDIV.S) that sits upstream of the floating-point register file. It takes rs1/rs2 operand values read from the FP register file and produces the write port triple (write enable, destination register, write data) plus exception flags. A single-entry start/done handshake lets the core stall while the unit is busy.

Parameters:
ITER, 26, quotient bits generated by the restoring divider: 24 mantissa + guard + round; the remainder supplies sticky.
CANON_NAN, 32'h7FC00000, canonical quiet NaN returned for all NaN results.

Ports:
iCLK  input  1  core clock; all state updates on posedge.
iRST_N  input  1  asynchronous reset, active-low.
iStart  input  1  request a divide; sampled only in IDLE.
iOperandA  input  32  dividend (rs1 read data).
iOperandB  input  32  divisor (rs2 read data).
iRd  input  5  destination FP register.
oBusy  output  1  high from the cycle after an accepted start until oDone.
oDone  output  1  one-cycle pulse when the result is valid.
oRegWrite  output  1  equals oDone; drives the register file write enable.
oWriteRegister  output  5  latched iRd; valid while oDone.
oResult  output  32  quotient; held until the next oDone.
oFlags  output  5  {NV,DZ,OF,UF,NX}; valid while oDone, held afterwards.

Behaviour:
- Reset (iRST_N=0, asynchronous): state=IDLE, oBusy=0, oDone=0, oRegWrite=0, oResult=0, oWriteRegister=0, oFlags=0, iteration counter=0. Takes effect immediately and aborts any operation in progress with no writeback.
- States: IDLE -> PREP -> DIV -> ROUND -> DONE -> IDLE.
- IDLE: if iStart=1, latch operands and iRd, then go to PREP. Otherwise stay in IDLE.
- In any other state, iStart is ignored; no queueing.
- PREP (1 cycle): unpack operands.
  - Subnormal inputs are treated as signed zero (DAZ).
  - Classify specials; compute sign = sA^sB and exponent = eA-eB+127 as a 10-bit signed value.
  - Mantissas get an implicit leading 1. Clear the counter.
- DIV (ITER cycles): restoring division, one quotient bit per cycle, MSB first. The counter runs 0..ITER-1, and the last count goes to ROUND.
- ROUND (1 cycle):
  - If quotient bit 25 = 0, shift the quotient left 1 and decrement the exponent.
  - Sticky = OR of the remainder bits.
  - Round to nearest, ties to even. A mantissa carry-out increments the exponent.
  - Exponent >= 255: result = ±inf, OF|NX.
  - Exponent <= 0: result = ±0, UF|NX (flush to zero).
  - NX is set when guard|round|sticky is nonzero.
- DONE (1 cycle): oDone=oRegWrite=1, oResult and oFlags updated. Next state is IDLE, so back-to-back starts are possible from the following cycle.
- Latency is fixed at ITER+3 = 29 cycles from the iStart sample edge to oDone high. Special cases take the same path; the datapath result is overridden in ROUND.
- Special cases (override the datapath result):
  - Either operand NaN -> CANON_NAN; NV only if either operand is sNaN.
  - 0/0 or inf/inf -> CANON_NAN, NV.
  - Finite nonzero / 0 -> ±inf, DZ.
  - inf / finite -> ±inf, no flags.
  - finite / inf -> ±0, no flags.
  - 0 / nonzero finite -> ±0, no flags.
- oBusy = 1 in PREP, DIV, ROUND; 0 in DONE and IDLE.

Test Plan:
- Basic divide: reset, then start 0x40C00000 / 0x40000000 with iRd=5 -> oDone exactly 29 cycles later with oResult=0x40400000, oWriteRegister=5, oFlags=0, oRegWrite=1 for one cycle only.
- Rounding: 0x3F800000 / 0x40400000 -> 0x3EAAAAAB, NX only (flags=5'b00001). Also 0xC0000000 / 0x3F800000 -> 0xC0000000, flags 0.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, DZ.
  - 0x00000000 / 0x80000000 -> 0x7FC00000, NV.
  - 0x7F800001 (sNaN) / 0x3F800000 -> 0x7FC00000, NV.
  - 0x7FC00000 / 0x3F800000 -> 0x7FC00000, flags 0.
- Range limits:
  - 0x7F7FFFFF / 0x3E800000 -> 0x7F800000, OF|NX.
  - 0x00800000 / 0x7F000000 -> 0x00000000, UF|NX.
  - Subnormal dividend 0x00000001 / 0x3F800000 -> 0x00000000, flags 0.
- Handshake: pulse iStart again during DIV with other operands -> ignored; only the first result appears, and oBusy stays high throughout. An iStart in the cycle after oDone is accepted.
- Reset mid-operation: drive iRST_N low at DIV cycle 10 -> oBusy=0 and outputs cleared asynchronously, with no oDone. After release, a fresh 6.0/2.0 gives the correct result in 29 cycles.
